pwm_peripheral: RTL



---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_peripheral_if.sv | 20 ++
 rtl/pwm_timebase.sv | 45 ++++
 rtl/pwm_peripheral.sv | 87 ++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - register map and PWM constants shared by the PWM peripheral
package pwm_pkg;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;
    localparam logic [6:0] MAX_ADDR       = 7'h04;

    localparam logic [7:0] PWM_TOP   = 8'd254;
    localparam logic [7:0] DUTY_FULL = 8'hFF;

    // Full duty is forced high so the compare never drops out at the wrap
    function automatic logic pwm_level(input logic [7:0] cnt, input logic [7:0] duty);
        return (duty == DUTY_FULL) || (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_peripheral_if.sv
// rtl/pwm_peripheral_if.sv - decoded register write port from the SPI stage
interface pwm_peripheral_if;

    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data
    );

    modport slave (
        input wr_valid,
        input wr_addr,
        input wr_data
    );

endinterface

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - clock prescaler and free-running 0..254 PWM counter
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = 13,
    parameter int DIV_W   = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic [7:0] o_pwm_cnt,
    output logic       o_wrap,
    output logic       o_period_start
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic [7:0]       r_pwm_cnt;
    logic             r_period_start;
    logic             w_tick;
    logic             w_wrap;

    assign w_tick = (r_div_cnt == DIV_LAST);
    assign w_wrap = w_tick && (r_pwm_cnt == PWM_TOP);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div_cnt      <= '0;
            r_pwm_cnt      <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            if (w_tick) begin
                r_pwm_cnt <= w_wrap ? 8'd0 : r_pwm_cnt + 8'd1;
            end
            // Registered so the pulse lines up with the cycle pwm_cnt reads 0
            r_period_start <= w_wrap;
        end
    end

    assign o_pwm_cnt      = r_pwm_cnt;
    assign o_wrap         = w_wrap;
    assign o_period_start = r_period_start;

endmodule

// File: rtl/pwm_peripheral.sv
// rtl/pwm_peripheral.sv - register file and 16-pin PWM output stage
// Optional PWM_SHADOW_EN: duty is latched into a shadow only at the period wrap.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int         CLK_DIV  = 13,
    parameter int         DIV_W    = 8,
    parameter logic [6:0] MAX_ADDR = pwm_pkg::MAX_ADDR
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    pwm_peripheral_if.slave         i_wr,
    output logic [15:0]             o_out,
    output logic                    o_period_start
);

    logic [15:0] r_en_out;
    logic [15:0] r_en_pwm;
    logic [7:0]  r_duty;
    logic [15:0] r_out;

    logic [7:0]  w_pwm_cnt;
    logic        w_wrap;
    logic        w_wr_ok;
    logic [7:0]  w_duty_act;
    logic        w_level;

    pwm_timebase #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W)
    ) u_timebase (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .o_pwm_cnt      (w_pwm_cnt),
        .o_wrap         (w_wrap),
        .o_period_start (o_period_start)
    );

    assign w_wr_ok = i_wr.wr_valid && (i_wr.wr_addr <= MAX_ADDR);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_en_out <= '0;
            r_en_pwm <= '0;
            r_duty   <= '0;
        end else if (w_wr_ok) begin
            case (i_wr.wr_addr)
                ADDR_EN_OUT_LO: r_en_out[7:0]  <= i_wr.wr_data;
                ADDR_EN_OUT_HI: r_en_out[15:8] <= i_wr.wr_data;
                ADDR_EN_PWM_LO: r_en_pwm[7:0]  <= i_wr.wr_data;
                ADDR_EN_PWM_HI: r_en_pwm[15:8] <= i_wr.wr_data;
                ADDR_DUTY:      r_duty         <= i_wr.wr_data;
                default: ;
            endcase
        end
    end

`ifdef PWM_SHADOW_EN
    logic [7:0] r_duty_shadow;

    // Loads the pre-write duty when a write lands on the wrap edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_duty_shadow <= '0;
        end else if (w_wrap) begin
            r_duty_shadow <= r_duty;
        end
    end

    assign w_duty_act = r_duty_shadow;
`else
    assign w_duty_act = r_duty;
`endif

    assign w_level = pwm_level(w_pwm_cnt, w_duty_act);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= r_en_out & (~r_en_pwm | {16{w_level}});
        end
    end

    assign o_out = r_out;

endmodule
